// File: rtl/player_jump_motion.sv
// Per-frame player kinematics: horizontal stepping with clamps plus a ballistic jump FSM.
// Optional mid-air second jump is compiled in with PLAYER_DOUBLE_JUMP_EN.
module player_jump_motion #(
  parameter logic [9:0] X_START       = 10'd100,
  parameter logic [9:0] Y_GROUND      = 10'd400,
  parameter logic [9:0] X_MIN         = 10'd0,
  parameter logic [9:0] X_MAX         = 10'd600,
  parameter logic [9:0] X_STEP        = 10'd2,
  parameter logic [4:0] JUMP_VELOCITY = 5'd8,
  parameter logic [4:0] GRAVITY       = 5'd1,
  parameter logic [4:0] MAX_FALL      = 5'd8,
  parameter logic [3:0] APEX_HOLD     = 4'd2
) (
  input  logic       frame_Clk,
  input  logic       Reset,
  input  logic       left,
  input  logic       right,
  input  logic       jump,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic       playerDirection,
  output logic       moving,
  output logic       inAir,
  output logic       landed
);

  typedef enum logic [1:0] {GROUND, RISING, APEX, FALLING} state_t;

  localparam logic [3:0] APEX_LAST = APEX_HOLD - 4'd1;

  state_t     r_state;
  logic [4:0] r_vel;
  logic [3:0] r_apex_cnt;
  logic       r_jump_prev;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic       r_air_jump_used;
`endif

  logic        w_jump_edge;
  logic [10:0] w_x_inc;
  logic [9:0]  w_x_next;
  logic        w_dir_next;
  logic        w_moving;
  logic [10:0] w_fall_sum;
  logic [5:0]  w_vel_inc;
  logic [4:0]  w_vel_fall;
  logic [9:0]  w_y_rise;

  assign w_jump_edge = jump & ~r_jump_prev;
  assign w_x_inc     = {1'b0, PlayerX} + {1'b0, X_STEP};
  assign w_fall_sum  = {1'b0, PlayerY} + {6'd0, r_vel};
  assign w_vel_inc   = {1'b0, r_vel} + {1'b0, GRAVITY};
  assign w_vel_fall  = (w_vel_inc > {1'b0, MAX_FALL}) ? MAX_FALL : w_vel_inc[4:0];
  assign w_y_rise    = (PlayerY >= {5'd0, r_vel}) ? (PlayerY - {5'd0, r_vel}) : 10'd0;

  // Horizontal motion applies in every vertical state (full air control).
  always_comb begin
    w_x_next   = PlayerX;
    w_dir_next = playerDirection;
    w_moving   = 1'b0;
    if (right && !left) begin
      w_x_next   = (w_x_inc > {1'b0, X_MAX}) ? X_MAX : w_x_inc[9:0];
      w_dir_next = 1'b0;
      w_moving   = 1'b1;
    end else if (left && !right) begin
      // Compare before subtracting so the unsigned value can never wrap.
      w_x_next   = ({1'b0, PlayerX} < ({1'b0, X_MIN} + {1'b0, X_STEP})) ? X_MIN : (PlayerX - X_STEP);
      w_dir_next = 1'b1;
      w_moving   = 1'b1;
    end
  end

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      PlayerX         <= X_START;
      PlayerY         <= Y_GROUND;
      playerDirection <= 1'b0;
      moving          <= 1'b0;
      inAir           <= 1'b0;
      landed          <= 1'b0;
      r_state         <= GROUND;
      r_vel           <= 5'd0;
      r_apex_cnt      <= 4'd0;
      r_jump_prev     <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      r_air_jump_used <= 1'b0;
`endif
    end else begin
      r_jump_prev     <= jump;
      PlayerX         <= w_x_next;
      playerDirection <= w_dir_next;
      moving          <= w_moving;
      landed          <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      // Second launch overrides whatever the airborne state would have done.
      if (r_state != GROUND && w_jump_edge && !r_air_jump_used) begin
        r_state         <= RISING;
        r_vel           <= JUMP_VELOCITY;
        r_air_jump_used <= 1'b1;
        inAir           <= 1'b1;
      end else
`endif
      case (r_state)
        GROUND: begin
          PlayerY <= Y_GROUND;
          if (w_jump_edge) begin
            r_state <= RISING;
            r_vel   <= JUMP_VELOCITY;
            inAir   <= 1'b1;
          end else begin
            inAir   <= 1'b0;
          end
        end
        RISING: begin
          PlayerY <= w_y_rise;
          inAir   <= 1'b1;
          if (r_vel <= GRAVITY) begin
            r_state    <= APEX;
            r_apex_cnt <= 4'd0;
            r_vel      <= 5'd0;
          end else begin
            r_vel <= r_vel - GRAVITY;
          end
        end
        APEX: begin
          r_apex_cnt <= r_apex_cnt + 4'd1;
          inAir      <= 1'b1;
          if (r_apex_cnt == APEX_LAST) begin
            r_state <= FALLING;
            r_vel   <= 5'd0;
          end
        end
        FALLING: begin
          if (w_fall_sum >= {1'b0, Y_GROUND}) begin
            PlayerY <= Y_GROUND;
            r_vel   <= 5'd0;
            r_state <= GROUND;
            landed  <= 1'b1;
            inAir   <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            r_air_jump_used <= 1'b0;
`endif
          end else begin
            PlayerY <= w_fall_sum[9:0];
            r_vel   <= w_vel_fall;
            inAir   <= 1'b1;
          end
        end
        default: begin
          r_state <= GROUND;
          PlayerY <= Y_GROUND;
          r_vel   <= 5'd0;
          inAir   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_jump_motion.sv
// Scoreboard bench for player_jump_motion: a physics-style reference model predicts each
// frame's outputs; a monitor compares them against the DUT on the falling edge.
module tb_player_jump_motion;

  logic       frame_Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       left = 1'b0, right = 1'b0, jump = 1'b0;
  logic [9:0] PlayerX, PlayerY;
  logic       playerDirection, moving, inAir, landed;

  always #5 frame_Clk = ~frame_Clk;

  player_jump_motion dut (
    .frame_Clk(frame_Clk), .Reset(Reset), .left(left), .right(right), .jump(jump),
    .PlayerX(PlayerX), .PlayerY(PlayerY), .playerDirection(playerDirection),
    .moving(moving), .inAir(inAir), .landed(landed)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dir;
    logic       mov;
    logic       air;
    logic       land;
  } obs_t;

  obs_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: signed-free physics with an upward speed, a fall speed and an apex timer.
  int m_x, m_y, m_up, m_fall, m_hold;
  bit m_dir, m_mov, m_air, m_land, m_jprev, m_used;

  task automatic model_step(input bit l, input bit r, input bit j, input bit rst);
    bit edge_j;
    if (rst) begin
      m_x = 100; m_y = 400; m_dir = 0; m_mov = 0; m_air = 0; m_land = 0;
      m_up = 0; m_fall = 0; m_hold = 0; m_jprev = 0; m_used = 0;
      return;
    end
    edge_j  = j && !m_jprev;
    m_jprev = j;
    if (r && !l) begin
      m_x = (m_x + 2 > 600) ? 600 : m_x + 2; m_dir = 0; m_mov = 1;
    end else if (l && !r) begin
      m_x = (m_x < 2) ? 0 : m_x - 2; m_dir = 1; m_mov = 1;
    end else begin
      m_mov = 0;
    end
    m_land = 0;
    if (!m_air) begin
      if (edge_j) begin m_air = 1; m_up = 8; m_hold = 0; end
`ifdef PLAYER_DOUBLE_JUMP_EN
    end else if (edge_j && !m_used) begin
      m_up = 8; m_hold = 0; m_used = 1;
`endif
    end else if (m_up > 0) begin
      m_y = (m_y >= m_up) ? m_y - m_up : 0;
      if (m_up <= 1) begin m_up = 0; m_hold = 2; m_fall = 0; end
      else m_up = m_up - 1;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1; m_fall = 0;
    end else if (m_y + m_fall >= 400) begin
      m_y = 400; m_fall = 0; m_air = 0; m_land = 1; m_used = 0;
    end else begin
      m_y = m_y + m_fall;
      m_fall = (m_fall + 1 > 8) ? 8 : m_fall + 1;
    end
  endtask

  task automatic tick(input bit l, input bit r, input bit j, input bit rst);
    obs_t e;
    left = l; right = r; jump = j; Reset = rst;
    @(posedge frame_Clk);
    #1;
    model_step(l, r, j, rst);
    e.x = m_x[9:0]; e.y = m_y[9:0]; e.dir = m_dir; e.mov = m_mov; e.air = m_air; e.land = m_land;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  // Monitor: every frame is an output; pop the prediction for the edge just taken.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge frame_Clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{PlayerX, PlayerY, playerDirection, moving, inAir, landed};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL frame t=%0t: got x=%0d y=%0d dir=%0b mov=%0b air=%0b land=%0b, want x=%0d y=%0d dir=%0b mov=%0b air=%0b land=%0b",
                   $time, a.x, a.y, a.dir, a.mov, a.air, a.land, e.x, e.y, e.dir, e.mov, e.air, e.land);
        end
      end
    end
  end

  initial begin
    int budget;
    bit l, r, j, rst;
    tick(0, 0, 0, 1); tick(0, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
    tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    for (int i = 0; i < 60; i++) tick(1, 0, 0, 0);   // runs into X_MIN and stays clamped
    for (int i = 0; i < 305; i++) tick(0, 1, 0, 0);  // runs into X_MAX and stays clamped
    for (int i = 0; i < 20; i++) tick(1, 0, 0, 0);
    // Single jump pulse, full profile and landing.
    tick(0, 0, 1, 0); idle(24);
    // Held button: exactly one launch.
    for (int i = 0; i < 40; i++) tick(0, 0, 1, 0);
    idle(5);
    // Edges at T0, T5 and T9.
    tick(0, 0, 1, 0); idle(4); tick(0, 0, 1, 0); idle(3); tick(0, 0, 1, 0); idle(40);
    // Edge coinciding with the landing tick must not launch.
    tick(0, 0, 1, 0); idle(18); tick(0, 0, 1, 0); tick(0, 0, 1, 0); idle(2);
    tick(0, 0, 1, 0); idle(30);
    // Reset mid-jump.
    tick(0, 1, 1, 0); idle(3); tick(0, 0, 0, 1); idle(3);
    // Randomized play.
    for (int i = 0; i < 600; i++) begin
      l   = ($urandom_range(0, 2) == 0);
      r   = ($urandom_range(0, 2) == 0);
      j   = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick(l, r, j, rst);
    end
    idle(2);
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge frame_Clk);
      budget++;
    end
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_jump_motion.md
Name: player_jump_motion

Overview:
- Per-frame player kinematics controller: converts button inputs into PlayerX/PlayerY, playerDirection, moving, and airborne status.
- Sits directly upstream of the player animation/sprite-address stages, which consume PlayerX, PlayerY, playerDirection and moving.
- Updates exactly once per frame_Clk edge (one edge per video frame).
- Jump uses a ballistic profile: fixed launch velocity, constant gravity, apex hold, capped fall speed.

Parameters:
- X_START, 10'd100, PlayerX after reset.
- Y_GROUND, 10'd400, floor PlayerY (top-left of the 40x40 sprite).
- X_MIN, 10'd0, left clamp for PlayerX.
- X_MAX, 10'd600, right clamp for PlayerX (640 - sprite width).
- X_STEP, 10'd2, horizontal pixels per frame.
- JUMP_VELOCITY, 5'd8, initial upward speed in pixels/frame.
- GRAVITY, 5'd1, speed change per frame.
- MAX_FALL, 5'd8, fall speed cap.
- APEX_HOLD, 4'd2, frames held at apex (must be >= 1).

Ports:
- frame_Clk  input  1  frame-rate clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high.
- left  input  1  move-left button level.
- right  input  1  move-right button level.
- jump  input  1  jump button level; rising edge detected internally.
- PlayerX  output  10  player left edge.
- PlayerY  output  10  player top edge.
- playerDirection  output  1  0 = facing right, 1 = facing left.
- moving  output  1  1 when a horizontal step was taken this frame.
- inAir  output  1  1 in any state other than GROUND.
- landed  output  1  one-frame pulse on the tick the player returns to Y_GROUND.

Behaviour:
- Reset: one clock on frame_Clk, synchronous, active-high. Register values after reset:
  - PlayerX = X_START, PlayerY = Y_GROUND
  - playerDirection = 0, moving = 0, inAir = 0, landed = 0
  - state = GROUND, vel = 0, apex counter = 0, jump_prev = 0
- Reset mid-jump returns to these values on the next edge.
- Jump edge: jump_edge = jump & ~jump_prev. jump_prev is registered every tick. A held button never retriggers.
- Horizontal motion (evaluated in every state, full air control):
  - right & ~left: PlayerX += X_STEP, saturating at X_MAX; playerDirection <= 0; moving <= 1.
  - left & ~right: PlayerX -= X_STEP, saturating at X_MIN with no unsigned underflow; playerDirection <= 1; moving <= 1.
  - Both or neither pressed: PlayerX held, playerDirection held, moving <= 0.
  - moving is 1 even while clamped at a limit, as long as the press is valid.
- Vertical FSM; vel is 5-bit unsigned, direction implied by state:
  - GROUND: PlayerY = Y_GROUND. On jump_edge: go to RISING, vel <= JUMP_VELOCITY; PlayerY unchanged this tick.
  - RISING: PlayerY <= PlayerY - vel, saturating at 0; vel <= vel - GRAVITY. If vel <= GRAVITY: go to APEX, counter <= 0, vel <= 0.
  - APEX: PlayerY held; counter++. When counter == APEX_HOLD-1: go to FALLING, vel <= 0.
  - FALLING: if PlayerY + vel >= Y_GROUND (11-bit compare): PlayerY <= Y_GROUND, vel <= 0, go to GROUND, landed <= 1. Otherwise PlayerY <= PlayerY + vel and vel <= min(vel + GRAVITY, MAX_FALL).
- landed is 0 on every other tick.
- inAir is registered and equals (next state != GROUND).
- jump_edge outside GROUND is ignored (unless the optional feature is enabled).
- A simultaneous jump_edge and landing tick does not launch; the jump needs a fresh edge on a later tick.
- Latency: every output reflects inputs sampled on the same edge (one-frame latency).

Optional Feature:
- Macro: PLAYER_DOUBLE_JUMP_EN.
- Enabled:
  - A one-bit airJumpUsed register, cleared on Reset and on landing.
  - A jump_edge in RISING, APEX or FALLING while airJumpUsed = 0 forces state RISING, vel <= JUMP_VELOCITY, airJumpUsed <= 1. PlayerY is unchanged that tick.
  - Further air edges are ignored.
- Disabled: the register and logic are absent; air edges are always ignored.

Test Plan:
- Reset held 2 ticks, then released with no buttons -> PlayerX=100, PlayerY=400, direction=0, moving=0, inAir=0, landed=0.
- right=1 for 5 ticks -> PlayerX=110, moving=1, direction=0. Then left=right=1 -> PlayerX holds at 110, moving=0, direction stays 0.
- PlayerX at 2, left=1 for 3 ticks -> PlayerX 0, 0, 0; direction=1; no wrap. Symmetric check at X_MAX=600 with right=1.
- jump pulse at tick T0 with defaults:
  - PlayerY over T1..T8 = 392, 385, 379, 374, 370, 367, 365, 364.
  - APEX at T9 and T10, PlayerY=364.
  - PlayerY over T11..T18 = 364, 365, 367, 370, 374, 379, 385, 392.
  - T19: PlayerY=400, landed=1 for one tick, inAir=0.
- jump held high for 40 ticks -> exactly one jump. A second edge at T5 is ignored (PlayerY profile as above). With PLAYER_DOUBLE_JUMP_EN, an edge at T5 resets vel to 8 and a third edge is ignored.
- Reset asserted at T4 of a jump -> next tick PlayerY=400, state GROUND, inAir=0, landed=0.
